// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the memory bus arbiter.
package mem_arb_pkg;

    localparam int AW_DEF = 64;
    localparam int DW_DEF = 64;
    localparam int MW_DEF = DW_DEF / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory bus port: request/grant/response handshake between arbiter (master) and memory (slave).
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int MW = MW_DEF
) ();

    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata, wmask,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wmask,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and MEM requesters.
// MEM_ARBITER_RR_EN selects round-robin; otherwise MEM has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req_i,
    input  logic   mem_req_i,
    input  owner_e last_owner_i,
    input  logic   blk_if_i,
    input  logic   blk_mem_i,
    output logic   valid_o,
    output owner_e owner_o
);

    logic if_v;
    logic mem_v;

    // A requester whose done pulse is in flight still holds a stale request.
    assign if_v  = if_req_i  & ~blk_if_i;
    assign mem_v = mem_req_i & ~blk_mem_i;

`ifdef MEM_ARBITER_RR_EN
    always_comb begin
        valid_o = if_v | mem_v;
        owner_o = OWN_IF;
        if (if_v && mem_v) begin
            owner_o = (last_owner_i == OWN_MEM) ? OWN_IF : OWN_MEM;
        end else if (mem_v) begin
            owner_o = OWN_MEM;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner_i;

    always_comb begin
        valid_o = if_v | mem_v;
        owner_o = OWN_IF;
        if (mem_v) begin
            owner_o = OWN_MEM;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory bus port between instruction fetch and the MEM stage, one transaction at a time.
// Optional round-robin arbitration via MEM_ARBITER_RR_EN (default: fixed MEM priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int MW = MW_DEF
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [DW-1:0] if_rdata_o,
    output logic          if_done_o,

    input  logic          mem_ren_i,
    input  logic [AW-1:0] mem_raddr_i,
    input  logic          mem_wen_i,
    input  logic [AW-1:0] mem_waddr_i,
    input  logic [DW-1:0] mem_wdata_i,
    input  logic [MW-1:0] mem_wmask_i,
    output logic [DW-1:0] mem_rdata_o,
    output logic          mem_done_o,

    mem_arbiter_if.master bus,

    output logic          stall_if_o,
    output logic          stall_mem_o
);

    state_e        state_q,     state_d;
    owner_e        owner_q,     owner_d;
    logic          bus_req_q,   bus_req_d;
    logic          bus_we_q,    bus_we_d;
    logic [AW-1:0] bus_addr_q,  bus_addr_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic [MW-1:0] bus_wmask_q, bus_wmask_d;
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic [DW-1:0] mem_rdata_q, mem_rdata_d;
    logic          if_done_q,   if_done_d;
    logic          mem_done_q,  mem_done_d;

    logic   mem_req;
    logic   pick_valid;
    owner_e pick_owner;
    owner_e last_owner;

`ifdef MEM_ARBITER_RR_EN
    owner_e last_owner_q, last_owner_d;
    assign last_owner = last_owner_q;
`else
    assign last_owner = OWN_IF;
`endif

    assign mem_req = mem_ren_i | mem_wen_i;

    mem_arb_pick u_pick (
        .if_req_i     (if_req_i),
        .mem_req_i    (mem_req),
        .last_owner_i (last_owner),
        .blk_if_i     (if_done_q),
        .blk_mem_i    (mem_done_q),
        .valid_o      (pick_valid),
        .owner_o      (pick_owner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wmask_d = bus_wmask_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
`ifdef MEM_ARBITER_RR_EN
        last_owner_d = last_owner_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    if (pick_owner == OWN_MEM && mem_wen_i && mem_wmask_i == '0) begin
                        // Empty write mask: complete locally without touching the bus.
                        mem_done_d = 1'b1;
`ifdef MEM_ARBITER_RR_EN
                        last_owner_d = OWN_MEM;
`endif
                    end else begin
                        owner_d   = pick_owner;
                        bus_req_d = 1'b1;
                        state_d   = ST_REQ;
                        if (pick_owner == OWN_MEM) begin
                            // Write wins when both ren and wen are set.
                            bus_we_d    = mem_wen_i;
                            bus_addr_d  = mem_wen_i ? mem_waddr_i : mem_raddr_i;
                            bus_wdata_d = mem_wen_i ? mem_wdata_i : '0;
                            bus_wmask_d = mem_wen_i ? mem_wmask_i : '0;
                        end else begin
                            bus_we_d    = 1'b0;
                            bus_addr_d  = if_addr_i;
                            bus_wdata_d = '0;
                            bus_wmask_d = '0;
                        end
                    end
                end
            end

            ST_REQ: begin
                if (bus.gnt) begin
                    bus_req_d = 1'b0;
                    state_d   = ST_RESP;
                end
            end

            ST_RESP: begin
                if (bus.rvalid) begin
                    state_d = ST_IDLE;
`ifdef MEM_ARBITER_RR_EN
                    last_owner_d = owner_q;
`endif
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = bus.rdata;
                        if_done_d  = 1'b1;
                    end else begin
                        mem_done_d = 1'b1;
                        if (!bus_we_q) begin
                            mem_rdata_d = bus.rdata;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wmask_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            last_owner_q <= OWN_IF;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wmask_q <= bus_wmask_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
`ifdef MEM_ARBITER_RR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign bus.req   = bus_req_q;
    assign bus.we    = bus_we_q;
    assign bus.addr  = bus_addr_q;
    assign bus.wdata = bus_wdata_q;
    assign bus.wmask = bus_wmask_q;

    assign if_rdata_o  = if_rdata_q;
    assign if_done_o   = if_done_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_done_o  = mem_done_q;

    assign stall_if_o  = if_req_i & ~if_done_q;
    assign stall_mem_o = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: bus model with programmable grant/response delays.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [63:0] if_addr_i;
    logic [63:0] if_rdata_o;
    logic        if_done_o;
    logic        mem_ren_i, mem_wen_i;
    logic [63:0] mem_raddr_i, mem_waddr_i, mem_wdata_i;
    logic [7:0]  mem_wmask_i;
    logic [63:0] mem_rdata_o;
    logic        mem_done_o;
    logic        stall_if_o, stall_mem_o;

    mem_arbiter_if #(.AW(64), .DW(64), .MW(8)) bus ();

    mem_arbiter #(.AW(64), .DW(64), .MW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_done_o   (if_done_o),
        .mem_ren_i   (mem_ren_i),
        .mem_raddr_i (mem_raddr_i),
        .mem_wen_i   (mem_wen_i),
        .mem_waddr_i (mem_waddr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_wmask_i (mem_wmask_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_done_o  (mem_done_o),
        .bus         (bus),
        .stall_if_o  (stall_if_o),
        .stall_mem_o (stall_mem_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] rdata;
    } bus_exp_t;

    typedef struct {
        logic        is_mem;
        logic [63:0] rdata;
    } done_exp_t;

    bus_exp_t    bus_q[$];
    done_exp_t   done_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          gnt_delay = 0;
    int          rv_delay = 0;
    bit          stray = 0;
    bit          gnt_seen = 0;
    logic [63:0] exp_mem_rdata = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_bus(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [7:0] wmask, input logic [63:0] rdata);
        bus_exp_t e;
        e.we = we; e.addr = addr; e.wdata = wdata; e.wmask = wmask; e.rdata = rdata;
        bus_q.push_back(e);
    endtask

    task automatic push_done(input logic is_mem, input logic [63:0] rdata);
        done_exp_t d;
        d.is_mem = is_mem; d.rdata = rdata;
        done_q.push_back(d);
    endtask

    // Memory-side model: grants after gnt_delay waiting cycles, responds rv_delay cycles after the grant cycle.
    initial begin
        int wait_cnt = 0;
        int rv_cnt = 0;
        bit pend = 0;
        logic [63:0] resp = '0;
        bus_exp_t snap;
        bus_exp_t e;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
        forever begin
            @(negedge clk);
            bus.gnt = 1'b0;
            bus.rvalid = 1'b0;
            if (pend) begin
                if (rv_cnt >= rv_delay) begin
                    bus.rvalid = 1'b1;
                    bus.rdata = resp;
                    pend = 0;
                end else begin
                    rv_cnt++;
                end
            end else if (bus.req === 1'b1) begin
                if (wait_cnt == 0) begin
                    snap.we = bus.we; snap.addr = bus.addr;
                    snap.wdata = bus.wdata; snap.wmask = bus.wmask;
                end else begin
                    check("hold_we", bus.we, snap.we);
                    check("hold_addr", bus.addr, snap.addr);
                    check("hold_wdata", bus.wdata, snap.wdata);
                    check("hold_wmask", bus.wmask, snap.wmask);
                end
                if (wait_cnt >= gnt_delay) begin
                    bus.gnt = 1'b1;
                    gnt_seen = 1;
                    if (bus_q.size() == 0) begin
                        check("bus_req_unexpected", bus.req, 1'b0);
                        resp = '0;
                    end else begin
                        e = bus_q.pop_front();
                        check("bus_we", bus.we, e.we);
                        check("bus_addr", bus.addr, e.addr);
                        check("bus_wdata", bus.wdata, e.wdata);
                        check("bus_wmask", bus.wmask, e.wmask);
                        resp = e.rdata;
                    end
                    pend = 1;
                    rv_cnt = 0;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else if (stray) begin
                bus.gnt = 1'b1;
                bus.rvalid = 1'b1;
                bus.rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            end
        end
    end

    // Completion monitor: every done pulse pops one scoreboard entry.
    initial begin
        done_exp_t d;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && (if_done_o || mem_done_o)) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", {62'b0, if_done_o, mem_done_o}, 64'd0);
                end else begin
                    d = done_q.pop_front();
                    check("done_if", if_done_o, !d.is_mem);
                    check("done_mem", mem_done_o, d.is_mem);
                    if (d.is_mem) check("mem_rdata", mem_rdata_o, d.rdata);
                    else          check("if_rdata", if_rdata_o, d.rdata);
                end
            end
        end
    end

    task automatic do_if(input logic [63:0] addr, input int exp_lat);
        int cyc = 0;
        bit done = 0;
        @(negedge clk); #1;
        if_req_i = 1'b1; if_addr_i = addr;
        #1 check("stall_if_raise", stall_if_o, 1'b1);
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (if_done_o) done = 1;
            else check("stall_if_wait", stall_if_o, 1'b1);
        end
        if (!done) check("if_timeout", if_done_o, 1'b1);
        else check("stall_if_done", stall_if_o, 1'b0);
        if (exp_lat >= 0) check("if_latency", cyc, exp_lat);
        #1 if_req_i = 1'b0;
        @(negedge clk);
        check("if_done_pulse", if_done_o, 1'b0);
    endtask

    task automatic do_mem(input logic ren, input logic wen, input logic [63:0] raddr,
                          input logic [63:0] waddr, input logic [63:0] wdata,
                          input logic [7:0] wmask, input int exp_lat, input bit scramble);
        int cyc = 0;
        bit done = 0;
        @(negedge clk); #1;
        mem_ren_i = ren; mem_wen_i = wen; mem_raddr_i = raddr;
        mem_waddr_i = waddr; mem_wdata_i = wdata; mem_wmask_i = wmask;
        #1 check("stall_mem_raise", stall_mem_o, 1'b1);
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (mem_done_o) done = 1;
            else check("stall_mem_wait", stall_mem_o, 1'b1);
            if (!done && scramble && cyc == 1) begin
                #1;
                mem_raddr_i = ~raddr; mem_waddr_i = ~waddr; mem_wdata_i = ~wdata;
            end
        end
        if (!done) check("mem_timeout", mem_done_o, 1'b1);
        else check("stall_mem_done", stall_mem_o, 1'b0);
        if (exp_lat >= 0) check("mem_latency", cyc, exp_lat);
        #1 mem_ren_i = 1'b0; mem_wen_i = 1'b0;
        @(negedge clk);
        check("mem_done_pulse", mem_done_o, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bus_req"}, bus.req, 1'b0);
        check({tag, "_bus_we"}, bus.we, 1'b0);
        check({tag, "_bus_addr"}, bus.addr, 64'd0);
        check({tag, "_bus_wdata"}, bus.wdata, 64'd0);
        check({tag, "_bus_wmask"}, {56'd0, bus.wmask}, 64'd0);
        check({tag, "_if_rdata"}, if_rdata_o, 64'd0);
        check({tag, "_mem_rdata"}, mem_rdata_o, 64'd0);
        check({tag, "_if_done"}, if_done_o, 1'b0);
        check({tag, "_mem_done"}, mem_done_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int lat_if, lat_mem;
        rst = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        mem_ren_i = 1'b0; mem_wen_i = 1'b0;
        mem_raddr_i = '0; mem_waddr_i = '0; mem_wdata_i = '0; mem_wmask_i = '0;
        #22;
        check_all_zero("reset");
        check("reset_stall_if", stall_if_o, 1'b0);
        check("reset_stall_mem", stall_mem_o, 1'b0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);

        // Fetch read, minimum latency.
        push_bus(1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'h0000_0013);
        push_done(1'b0, 64'h0000_0013);
        do_if(64'h8000_0000, 3);

        // MEM read with one-cycle response delay.
        rv_delay = 1;
        push_bus(1'b0, 64'h2000, 64'd0, 8'h00, 64'hCAFE_F00D_1234_5678);
        exp_mem_rdata = 64'hCAFE_F00D_1234_5678;
        push_done(1'b1, exp_mem_rdata);
        do_mem(1'b1, 1'b0, 64'h2000, 64'd0, 64'd0, 8'h00, 4, 1'b0);

        // MEM write, grant delayed three cycles; inputs scrambled after selection.
        rv_delay = 0; gnt_delay = 3;
        push_bus(1'b1, 64'h1000, 64'hDEAD_BEEF, 8'h0F, 64'h5555_5555);
        push_done(1'b1, exp_mem_rdata);
        do_mem(1'b0, 1'b1, 64'h0, 64'h1000, 64'hDEAD_BEEF, 8'h0F, 6, 1'b1);
        gnt_delay = 0;

        // Both pending; last completion was MEM.
`ifdef MEM_ARBITER_RR_EN
        push_bus(1'b0, 64'h8000_0004, 64'd0, 8'h00, 64'h93);
        push_done(1'b0, 64'h93);
        push_bus(1'b0, 64'h3000, 64'd0, 8'h00, 64'hAAAA);
        push_done(1'b1, 64'hAAAA);
        lat_if = 3; lat_mem = 6;
`else
        push_bus(1'b0, 64'h3000, 64'd0, 8'h00, 64'hAAAA);
        push_done(1'b1, 64'hAAAA);
        push_bus(1'b0, 64'h8000_0004, 64'd0, 8'h00, 64'h93);
        push_done(1'b0, 64'h93);
        lat_if = 6; lat_mem = 3;
`endif
        exp_mem_rdata = 64'hAAAA;
        fork
            do_if(64'h8000_0004, lat_if);
            do_mem(1'b1, 1'b0, 64'h3000, 64'd0, 64'd0, 8'h00, lat_mem, 1'b0);
        join

        // ren and wen together: write wins.
        push_bus(1'b1, 64'h5000, 64'h1122, 8'hF0, 64'h7777);
        push_done(1'b1, exp_mem_rdata);
        do_mem(1'b1, 1'b1, 64'h4000, 64'h5000, 64'h1122, 8'hF0, 3, 1'b0);

        // Empty mask: local completion, stray gnt/rvalid while idle.
        stray = 1;
        push_done(1'b1, exp_mem_rdata);
        do_mem(1'b0, 1'b1, 64'd0, 64'h6000, 64'h77, 8'h00, 1, 1'b0);
        repeat (3) @(negedge clk);
        stray = 0;
        check("stray_mem_rdata", mem_rdata_o, exp_mem_rdata);

        // Reset during RESP, response arrives after release.
        rv_delay = 4;
        gnt_seen = 0;
        push_bus(1'b0, 64'h8000_0100, 64'd0, 8'h00, 64'h99);
        @(negedge clk); #1;
        if_req_i = 1'b1; if_addr_i = 64'h8000_0100;
        c = 0;
        while (!gnt_seen && c < 50) begin
            @(negedge clk); #2;
            c++;
        end
        check("rst_test_gnt", gnt_seen, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        if_req_i = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk); rst = 1'b1;
        exp_mem_rdata = '0;
        repeat (8) @(negedge clk);
        check_all_zero("post_rst");

        // Normal service after reset.
        rv_delay = 0;
        push_bus(1'b0, 64'h8000_0200, 64'd0, 8'h00, 64'h1234);
        push_done(1'b0, 64'h1234);
        do_if(64'h8000_0200, 3);
        push_bus(1'b0, 64'h2400, 64'd0, 8'h00, 64'h0F0F_0F0F);
        exp_mem_rdata = 64'h0F0F_0F0F;
        push_done(1'b1, exp_mem_rdata);
        do_mem(1'b1, 1'b0, 64'h2400, 64'd0, 64'd0, 8'h00, 3, 1'b0);

        repeat (3) @(negedge clk);
        check("done_q_drained", done_q.size(), 64'd0);
        check("bus_q_drained", bus_q.size(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
